// File: rtl/vga_bars_scheduler_pkg.sv
// rtl/vga_bars_scheduler_pkg.sv - shared constants, state enum, index type and sine table for the bar scheduler
package vga_bars_pkg;

    localparam int TABLE_LEN      = 120;
    localparam int SAMPLE_W       = 9;
    localparam int SINE_AMPLITUDE = 200;
    localparam int IDX_W          = $clog2(TABLE_LEN) + 1;

    typedef logic [IDX_W-1:0]           idx_t;
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        COMMIT
    } state_t;

    // round(sin(k*3deg)*200) for the first quadrant, k = 0..30
    function automatic int quarter_wave(input int k);
        case (k)
            0:  return 0;    1:  return 10;   2:  return 21;   3:  return 31;
            4:  return 42;   5:  return 52;   6:  return 62;   7:  return 72;
            8:  return 81;   9:  return 91;   10: return 100;  11: return 109;
            12: return 118;  13: return 126;  14: return 134;  15: return 141;
            16: return 149;  17: return 155;  18: return 162;  19: return 168;
            20: return 173;  21: return 178;  22: return 183;  23: return 187;
            24: return 190;  25: return 193;  26: return 196;  27: return 198;
            28: return 199;  29: return 200;
            default: return SINE_AMPLITUDE;
        endcase
    endfunction

    function automatic sample_t sine_sample(input int i);
        int v;
        if (i < TABLE_LEN / 4)           v = quarter_wave(i);
        else if (i < TABLE_LEN / 2)      v = quarter_wave(TABLE_LEN / 2 - i);
        else if (i < 3 * TABLE_LEN / 4)  v = -quarter_wave(i - TABLE_LEN / 2);
        else                             v = -quarter_wave(TABLE_LEN - i);
        return sample_t'(v);
    endfunction

endpackage

// File: rtl/vga_bars_scheduler_if.sv
// rtl/vga_bars_scheduler_if.sv - frame tick / split-line bundle; o_Overruns present only with OVERRUN_COUNT_EN
interface vga_bars_scheduler_if #(
    parameter int NUM_BARS = 4,
    parameter int SAMPLE_W = vga_bars_pkg::SAMPLE_W
);
    logic                         i_NewFrameTick;
    logic                         i_Enable;
    logic [NUM_BARS*SAMPLE_W-1:0] o_SplitLines;
    logic                         o_Valid;
    logic                         o_Busy;
`ifdef OVERRUN_COUNT_EN
    logic [7:0]                   o_Overruns;

    modport master (
        output i_NewFrameTick, i_Enable,
        input  o_SplitLines, o_Valid, o_Busy, o_Overruns
    );
    modport slave (
        input  i_NewFrameTick, i_Enable,
        output o_SplitLines, o_Valid, o_Busy, o_Overruns
    );
`else
    modport master (
        output i_NewFrameTick, i_Enable,
        input  o_SplitLines, o_Valid, o_Busy
    );
    modport slave (
        input  i_NewFrameTick, i_Enable,
        output o_SplitLines, o_Valid, o_Busy
    );
`endif
endinterface

// File: rtl/vga_bars_scheduler_sine_rom.sv
// rtl/vga_bars_scheduler_sine_rom.sv - synchronous-read sine ROM, TABLE_LEN x SAMPLE_W, one cycle latency
module sine_rom
    import vga_bars_pkg::*;
(
    input  logic    i_Clk,
    input  idx_t    i_Addr,
    output sample_t o_Data
);
    sample_t data_q, data_d;

    always_comb begin
        data_d = '0;
        if (i_Addr < idx_t'(TABLE_LEN)) begin
            data_d = sine_sample(int'(i_Addr));
        end
    end

    always_ff @(posedge i_Clk) begin
        data_q <= data_d;
    end

    assign o_Data = data_q;

endmodule

// File: rtl/vga_bars_scheduler.sv
// rtl/vga_bars_scheduler.sv - per-frame sine fetch for all bars over one shared ROM
// Optional OVERRUN_COUNT_EN adds a saturating count of dropped frame ticks.
module vga_bars_scheduler
    import vga_bars_pkg::*;
#(
    parameter int NUM_BARS   = 4,
    parameter int PHASE_STEP = 30
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    vga_bars_scheduler_if.slave bus
);
    localparam int               BAR_W    = $clog2(NUM_BARS + 1);
    localparam idx_t             STEP_IDX = idx_t'(PHASE_STEP);
    localparam idx_t             LEN_IDX  = idx_t'(TABLE_LEN);
    localparam idx_t             LAST_IDX = idx_t'(TABLE_LEN - 1);
    localparam logic [BAR_W-1:0] LAST_BAR = BAR_W'(NUM_BARS);

    state_t                       state_q, state_d;
    idx_t                         base_q, base_d;
    idx_t                         addr_idx_q, addr_idx_d;
    logic [BAR_W-1:0]             bar_q, bar_d;
    sample_t                      shadow_q [NUM_BARS];
    sample_t                      shadow_d [NUM_BARS];
    logic [NUM_BARS*SAMPLE_W-1:0] split_q, split_d;
    logic                         valid_q, valid_d;
    logic                         busy_q, busy_d;
    idx_t                         step_sum;
    sample_t                      rom_data;
    logic                         start;

    assign start = bus.i_NewFrameTick && bus.i_Enable;

    sine_rom u_rom (
        .i_Clk  (i_Clk),
        .i_Addr (addr_idx_q),
        .o_Data (rom_data)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        addr_idx_d = addr_idx_q;
        bar_d      = bar_q;
        shadow_d   = shadow_q;
        split_d    = split_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        step_sum   = addr_idx_q + STEP_IDX;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    addr_idx_d = base_q;
                    bar_d      = '0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                addr_idx_d = (step_sum >= LEN_IDX) ? step_sum - LEN_IDX : step_sum;
                bar_d      = bar_q + BAR_W'(1);
                // ROM output now belongs to the address presented last cycle
                for (int k = 0; k < NUM_BARS; k++) begin
                    if (bar_q == BAR_W'(k + 1)) begin
                        shadow_d[k] = rom_data;
                    end
                end
                // Last sample is bypassed so split lines and o_Valid appear in the COMMIT cycle
                if (bar_q == LAST_BAR) begin
                    state_d = COMMIT;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    for (int k = 0; k < NUM_BARS; k++) begin
                        split_d[k*SAMPLE_W +: SAMPLE_W] = shadow_d[k];
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
                base_d  = (base_q == LAST_IDX) ? '0 : base_q + idx_t'(1);
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            addr_idx_q <= '0;
            bar_q      <= '0;
            split_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            for (int k = 0; k < NUM_BARS; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            addr_idx_q <= addr_idx_d;
            bar_q      <= bar_d;
            split_q    <= split_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            for (int k = 0; k < NUM_BARS; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

    assign bus.o_SplitLines = split_q;
    assign bus.o_Valid      = valid_q;
    assign bus.o_Busy       = busy_q;

`ifdef OVERRUN_COUNT_EN
    logic [7:0] overruns_q, overruns_d;

    // Any accepted-looking tick outside IDLE is lost, including one landing on COMMIT
    always_comb begin
        overruns_d = overruns_q;
        if (start && (state_q != IDLE) && (overruns_q != 8'hFF)) begin
            overruns_d = overruns_q + 8'd1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) overruns_q <= '0;
        else         overruns_q <= overruns_d;
    end

    assign bus.o_Overruns = overruns_q;
`endif

endmodule

// File: tb/tb_vga_bars_scheduler.sv
// tb/tb_vga_bars_scheduler.sv - randomized and directed bench against a frame-level reference model
module tb_vga_bars_scheduler;

    localparam int  NB   = 4;
    localparam int  STEP = 30;
    localparam int  TL   = 120;
    localparam int  SW   = 9;
    localparam int  W    = NB * SW;
    localparam real PI   = 3.14159265358979;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_bars_scheduler_if #(.NUM_BARS(NB), .SAMPLE_W(SW)) bus ();

    vga_bars_scheduler #(.NUM_BARS(NB), .PHASE_STEP(STEP)) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    int          m_cyc      = 0;
    int          m_base     = 0;
    int          m_fbase    = 0;
    int          m_start    = 0;
    bit          m_inflight = 1'b0;
    int          m_drops    = 0;
    logic [W-1:0] m_split   = '0;
    int          valid_seen = 0;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, m_cyc);
        end
    endtask

    function automatic int sine_ref(input int i);
        real r;
        r = 200.0 * $sin(real'(i) * 3.0 * PI / 180.0);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    function automatic logic [W-1:0] frame_ref(input int b);
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < NB; k++) begin
            v[k*SW +: SW] = SW'(sine_ref((b + k * STEP) % TL));
        end
        return v;
    endfunction

    function automatic logic [W-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [W-1:0] v;
        v = {SW'(d), SW'(c), SW'(b), SW'(a)};
        return v;
    endfunction

    // one clock: drive inputs, model the edge, compare outputs on the falling edge
    task automatic step(input bit tick, input bit en, input bit r);
        bit exp_valid;
        bit exp_busy;
        bus.i_NewFrameTick = tick;
        bus.i_Enable       = en;
        rst                = r;
        @(posedge clk);
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
        if (r) begin
            m_base     = 0;
            m_split    = '0;
            m_inflight = 1'b0;
            m_drops    = 0;
        end else begin
            // a frame occupies seven edges: accept, five fetch edges, commit
            if (m_inflight && m_cyc >= m_start + 7) m_inflight = 1'b0;
            if (tick && en) begin
                if (m_inflight) begin
                    if (m_drops < 255) m_drops++;
                end else begin
                    m_inflight = 1'b1;
                    m_start    = m_cyc;
                    m_fbase    = m_base;
                    m_base     = (m_base + 1) % TL;
                end
            end
            if (m_inflight && m_cyc == m_start + NB + 1) begin
                exp_valid = 1'b1;
                m_split   = frame_ref(m_fbase);
            end
            exp_busy = m_inflight && (m_cyc <= m_start + NB);
        end
        m_cyc++;
        @(negedge clk);
        if (bus.o_Valid === 1'b1) valid_seen++;
        expect_eq("valid", 64'(bus.o_Valid), 64'(exp_valid));
        expect_eq("busy", 64'(bus.o_Busy), 64'(exp_busy));
        expect_eq("split", 64'(bus.o_SplitLines), 64'(m_split));
`ifdef OVERRUN_COUNT_EN
        expect_eq("overruns", 64'(bus.o_Overruns), 64'(m_drops));
`endif
    endtask

    task automatic frame(input int idle_cycles);
        step(1'b1, 1'b1, 1'b0);
        repeat (idle_cycles) step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        bus.i_NewFrameTick = 1'b0;
        bus.i_Enable       = 1'b0;
        rst                = 1'b1;

        repeat (3) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        expect_eq("reset_split", 64'(bus.o_SplitLines), 64'd0);
        expect_eq("reset_busy", 64'(bus.o_Busy), 64'd0);

        frame(7);
        expect_eq("frame_base0", 64'(bus.o_SplitLines), 64'(pack4(0, 200, 0, -200)));
        frame(7);
        expect_eq("frame_base1", 64'(bus.o_SplitLines), 64'(pack4(10, 200, -10, -200)));

        repeat (117) frame(6);
        frame(7);
        expect_eq("frame_base119", 64'(bus.o_SplitLines), 64'(pack4(-10, 200, 10, -200)));
        frame(7);
        expect_eq("frame_wrap", 64'(bus.o_SplitLines), 64'(pack4(0, 200, 0, -200)));

        // tick while busy, then a tick landing on COMMIT
        valid_seen = 0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b1, 1'b0);
        expect_eq("overrun_one_valid", 64'(valid_seen), 64'd1);
`ifdef OVERRUN_COUNT_EN
        expect_eq("overrun_count2", 64'(bus.o_Overruns), 64'd2);
`endif

        repeat (320) step(1'b1, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b1, 1'b0);
`ifdef OVERRUN_COUNT_EN
        expect_eq("overrun_saturate", 64'(bus.o_Overruns), 64'd255);
`endif

        // reset three edges into a fetch
        valid_seen = 0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        repeat (8) step(1'b0, 1'b1, 1'b0);
        expect_eq("midrun_reset_no_valid", 64'(valid_seen), 64'd0);
        expect_eq("midrun_reset_split", 64'(bus.o_SplitLines), 64'd0);
        frame(7);
        expect_eq("after_reset_frame", 64'(bus.o_SplitLines), 64'(pack4(0, 200, 0, -200)));

        // disabled ticks must not start a fetch or move the base
        valid_seen = 0;
        repeat (5) begin
            step(1'b1, 1'b0, 1'b0);
            expect_eq("disabled_busy", 64'(bus.o_Busy), 64'd0);
            step(1'b0, 1'b0, 1'b0);
        end
        expect_eq("disabled_no_valid", 64'(valid_seen), 64'd0);
        expect_eq("disabled_hold", 64'(bus.o_SplitLines), 64'(pack4(0, 200, 0, -200)));
        frame(7);
        expect_eq("disabled_base_kept", 64'(bus.o_SplitLines), 64'(pack4(10, 200, -10, -200)));

        repeat (1500) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end
        repeat (8) step(1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
